mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter ACCESS_CYCLES, default 2, cycles memory signals are held per access (legal range 1..15).
REQ-004 Parameter STARVE_LIMIT, default 4, consecutive data grants tolerated while instruction request pending (legal range 1..15).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 if_req  in  1  instruction-fetch read request, held until if_ack.
REQ-008 if_adr  in  ADDR_W  instruction-fetch address.
REQ-009 if_rdata  out  DATA_W  fetched word, registered.
REQ-010 if_ack  out  1  one-cycle completion pulse, instruction port.
REQ-011 d_req  in  1  data-port request, held until d_ack.
REQ-012 d_we  in  1  data-port write enable (1 write, 0 read).
REQ-013 d_adr  in  ADDR_W  data-port address.
REQ-014 d_wdata  in  DATA_W  data-port write word.
REQ-015 d_rdata  out  DATA_W  data-port read word, registered.
REQ-016 d_ack  out  1  one-cycle completion pulse, data port.
REQ-017 mem_adr  out  ADDR_W  shared memory address.
REQ-018 mem_wdata  out  DATA_W  shared memory write data.
REQ-019 mem_read  out  1  shared memory read enable.
REQ-020 mem_write  out  1  shared memory write enable.
REQ-021 mem_rdata  in  DATA_W  shared memory read data, combinational from mem_adr.

Function
REQ-022 FSM states IDLE, BUSY, DONE; IDLE -> BUSY on any sampled request; BUSY -> DONE when cycle counter reaches 0; DONE -> IDLE unconditionally.
REQ-023 In IDLE, grant and latch owner, address, write data, write enable from the winning port; cycle counter loaded with ACCESS_CYCLES-1.
REQ-024 Arbitration: data port wins when both requests high, except when starve counter equals STARVE_LIMIT, then instruction port wins.
REQ-025 Starve counter: increments (saturating at STARVE_LIMIT) on each data grant made while if_req high; clears on every instruction grant.
REQ-026 mem_adr/mem_wdata driven from latched values only; mem_read = BUSY & latched read; mem_write = BUSY & latched write; both 0 in IDLE and DONE.
REQ-027 Instruction grants are always reads; mem_write never asserted for instruction owner.
REQ-028 On BUSY->DONE edge of a read, owner's rdata register loads mem_rdata; other port's rdata unchanged; writes leave both rdata registers unchanged.
REQ-029 Owner's ack high exactly during the DONE cycle; never both acks high; ack never high outside DONE.
REQ-030 Latency: request sampled at edge N -> ack high in cycle N+ACCESS_CYCLES+1; rdata valid with ack and held until owner's next read completes.
REQ-031 Requests are ignored in BUSY and DONE; input changes during BUSY do not affect latched access.
REQ-032 Requester samples ack and must deassert or change req by next rising edge; req still high in IDLE is a new request.
REQ-033 Back-to-back: with both ports requesting continuously, no idle cycle besides DONE; period = ACCESS_CYCLES+2 cycles per access.

Reset
REQ-034 While rst high at rising edge: state IDLE, counters 0, mem_read/mem_write/if_ack/d_ack 0, mem_adr/mem_wdata/if_rdata/d_rdata 0.
REQ-035 rst during BUSY or DONE aborts access: no ack issued, no rdata update, mem_write deasserted from the next cycle.

Verification
REQ-036 ACCESS_CYCLES=2, mem[5]=15, d_req read d_adr=5 alone -> mem_read high 2 cycles, d_ack 3rd cycle after sampling edge, d_rdata=15.
REQ-037 if_req if_adr=4 and d_req write d_adr=9 d_wdata=77 same cycle -> data granted first (mem_write 2 cycles, mem[9]=77, d_ack), then instruction, if_rdata=4, if_ack.
REQ-038 Both requests held continuously, STARVE_LIMIT=4 -> 4 data grants then 1 instruction grant, pattern repeats; acks never overlap.
REQ-039 rst asserted in 2nd BUSY cycle of write d_adr=9 -> no d_ack, mem_write low next cycle, all outputs 0, state IDLE.
REQ-040 ACCESS_CYCLES=1, if read adr=4 then data read adr=5 -> if_ack with if_rdata=4, d_ack 3 cycles later with d_rdata=15, if_rdata still 4.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of one shared memory with
// combinational read data. Fixed-length accesses; data port has priority with a starvation bound.
module mem_arbiter #(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int ACCESS_CYCLES = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_adr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_adr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [3:0] CNT_INIT   = 4'(ACCESS_CYCLES - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        starve_q, starve_d;
   logic              owner_d_q, owner_d_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              grant_if;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      starve_d   = starve_q;
      owner_d_d  = owner_d_q;
      we_d       = we_q;
      adr_d      = adr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      // Instruction port wins only when alone or once the data port has used up its quota.
      grant_if   = if_req && (!d_req || (starve_q == STARVE_MAX));

      case (state_q)
         ST_IDLE: begin
            if (if_req || d_req) begin
               state_d = ST_BUSY;
               cnt_d   = CNT_INIT;
               if (grant_if) begin
                  owner_d_d = 1'b0;
                  adr_d     = if_adr;
                  wdata_d   = '0;
                  we_d      = 1'b0;
                  starve_d  = '0;
               end else begin
                  owner_d_d = 1'b1;
                  adr_d     = d_adr;
                  wdata_d   = d_wdata;
                  we_d      = d_we;
                  if (if_req && (starve_q != STARVE_MAX)) begin
                     starve_d = starve_q + 4'd1;
                  end
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
               if (!we_q) begin
                  if (owner_d_q) begin
                     d_rdata_d = mem_rdata;
                  end else begin
                     if_rdata_d = mem_rdata;
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         starve_q   <= '0;
         owner_d_q  <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
         owner_d_q  <= owner_d_d;
         we_q       <= we_d;
         adr_q      <= adr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign mem_adr   = adr_q;
   assign mem_wdata = wdata_q;
   assign mem_read  = (state_q == ST_BUSY) && !we_q;
   assign mem_write = (state_q == ST_BUSY) && we_q;
   assign if_ack    = (state_q == ST_DONE) && !owner_d_q;
   assign d_ack     = (state_q == ST_DONE) && owner_d_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timeline model checked every cycle for the main instance,
// plus directed scenarios with literal expectations (second instance uses one-cycle accesses).
module tb_mem_arbiter;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam int AC = 2;
   localparam int SL = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          if_req, d_req, d_we;
   logic [AW-1:0] if_adr, d_adr, mem_adr;
   logic [DW-1:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
   logic          if_ack, d_ack, mem_read, mem_write;

   logic          u1_if_req, u1_d_req, u1_d_we;
   logic [AW-1:0] u1_if_adr, u1_d_adr, u1_mem_adr;
   logic [DW-1:0] u1_d_wdata, u1_if_rdata, u1_d_rdata, u1_mem_wdata, u1_mem_rdata;
   logic          u1_if_ack, u1_d_ack, u1_mem_read, u1_mem_write;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_adr(if_adr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1), .STARVE_LIMIT(SL)) dut1 (
      .clk(clk), .rst(rst),
      .if_req(u1_if_req), .if_adr(u1_if_adr), .if_rdata(u1_if_rdata), .if_ack(u1_if_ack),
      .d_req(u1_d_req), .d_we(u1_d_we), .d_adr(u1_d_adr), .d_wdata(u1_d_wdata),
      .d_rdata(u1_d_rdata), .d_ack(u1_d_ack),
      .mem_adr(u1_mem_adr), .mem_wdata(u1_mem_wdata), .mem_read(u1_mem_read),
      .mem_write(u1_mem_write), .mem_rdata(u1_mem_rdata)
   );

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_word(input int i);
      return (i == 5) ? DW'(15) : DW'(i);
   endfunction

   // Environment memories: combinational read, write on clock edge, re-initialised by reset.
   logic [DW-1:0] mem  [256];
   logic [DW-1:0] mem1 [256];
   assign mem_rdata    = mem[mem_adr];
   assign u1_mem_rdata = mem1[u1_mem_adr];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) begin
            mem[i]  <= init_word(i);
            mem1[i] <= init_word(i);
         end
      end else begin
         if (mem_write)    mem[mem_adr]     <= mem_wdata;
         if (u1_mem_write) mem1[u1_mem_adr] <= u1_mem_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: an access is a window of AC memory cycles followed by one acknowledge cycle.
   int            m_age = 0;
   int            m_starve = 0;
   logic          m_owner_d = 1'b0;
   logic          m_we = 1'b0;
   logic [AW-1:0] m_adr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] exp_if_rdata = '0;
   logic [DW-1:0] exp_d_rdata = '0;
   logic [DW-1:0] exp_mem [256];
   logic          model_valid = 1'b0;
   logic          m_pick_if;

   assign m_pick_if = if_req && (!d_req || (m_starve >= SL));

   always @(posedge clk) begin
      model_valid <= 1'b1;
      if (rst) begin
         m_age        <= 0;
         m_starve     <= 0;
         m_owner_d    <= 1'b0;
         m_we         <= 1'b0;
         m_adr        <= '0;
         m_wdata      <= '0;
         exp_if_rdata <= '0;
         exp_d_rdata  <= '0;
         for (int i = 0; i < 256; i++) exp_mem[i] <= init_word(i);
      end else if (m_age == 0) begin
         if (if_req || d_req) begin
            m_age <= 1;
            if (m_pick_if) begin
               m_owner_d <= 1'b0;
               m_adr     <= if_adr;
               m_we      <= 1'b0;
               m_starve  <= 0;
            end else begin
               m_owner_d <= 1'b1;
               m_adr     <= d_adr;
               m_we      <= d_we;
               m_wdata   <= d_wdata;
               if (if_req) m_starve <= (m_starve + 1 > SL) ? SL : m_starve + 1;
            end
         end
      end else if (m_age <= AC) begin
         if (m_age == AC) begin
            if (m_we)           exp_mem[m_adr] <= m_wdata;
            else if (m_owner_d) exp_d_rdata    <= exp_mem[m_adr];
            else                exp_if_rdata   <= exp_mem[m_adr];
         end
         m_age <= m_age + 1;
      end else begin
         m_age <= 0;
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("mem_read",  32'(mem_read),  32'((m_age >= 1) && (m_age <= AC) && !m_we));
         chk("mem_write", 32'(mem_write), 32'((m_age >= 1) && (m_age <= AC) && m_we));
         chk("if_ack",    32'(if_ack),    32'((m_age == AC + 1) && !m_owner_d));
         chk("d_ack",     32'(d_ack),     32'((m_age == AC + 1) && m_owner_d));
         chk("ack_overlap", 32'(if_ack && d_ack), 32'(0));
         chk("if_rdata",  32'(if_rdata),  32'(exp_if_rdata));
         chk("d_rdata",   32'(d_rdata),   32'(exp_d_rdata));
         chk("mem_adr",   32'(mem_adr),   32'(m_adr));
         if ((m_age >= 1) && (m_age <= AC) && m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
         if ((m_age == AC + 1) && m_we) chk("mem_contents", 32'(mem[m_adr]), 32'(exp_mem[m_adr]));
      end
   end

   task automatic wait_any(output int ack_cyc, output logic was_d, output int rd_cnt, output int wr_cnt);
      ack_cyc = -1;
      was_d   = 1'b0;
      rd_cnt  = 0;
      wr_cnt  = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mem_read)  rd_cnt++;
         if (mem_write) wr_cnt++;
         if (if_ack || d_ack) begin
            ack_cyc = cyc;
            was_d   = d_ack;
            break;
         end
      end
      if (ack_cyc < 0) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: no acknowledge within 40 cycles (cycle %0d)", cyc);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int            t0, ca, cb, rd, wr, prev;
      logic          wd;
      logic [7:0]    got [10];
      string         exp_pat;
      int            u1_rd, u1_wr, ci, cd;

      rst = 1'b1;
      if_req = 1'b0; if_adr = '0; d_req = 1'b0; d_we = 1'b0; d_adr = '0; d_wdata = '0;
      u1_if_req = 1'b0; u1_if_adr = '0; u1_d_req = 1'b0; u1_d_we = 1'b0;
      u1_d_adr = '0; u1_d_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {mem_read, mem_write, if_ack, d_ack, 28'h0}, 32'h0);
      chk("reset_mem_adr", 32'(mem_adr), 32'h0);
      chk("reset_mem_wdata", 32'(mem_wdata), 32'h0);
      chk("reset_rdata", {if_rdata, d_rdata}, 32'h0);
      @(posedge clk); #1 rst = 1'b0;

      // Single data read of address 5.
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_adr = 8'd5;
      t0 = cyc + 1;
      wait_any(ca, wd, rd, wr);
      d_req = 1'b0;
      $display("data read adr 5: ack cycle %0d, d_rdata %0d", ca - t0 + 1, d_rdata);
      chk("rd_ack_port", 32'(wd), 32'(1));
      chk("rd_ack_ordinal", 32'(ca - t0 + 1), 32'(3));
      chk("rd_mem_read_cycles", 32'(rd), 32'(2));
      chk("rd_d_rdata", 32'(d_rdata), 32'(15));

      // Simultaneous instruction read and data write: data first.
      @(posedge clk); #1;
      if_req = 1'b1; if_adr = 8'd4;
      d_req = 1'b1; d_we = 1'b1; d_adr = 8'd9; d_wdata = 16'd77;
      wait_any(ca, wd, rd, wr);
      d_req = 1'b0; d_we = 1'b0;
      $display("write adr 9: ack port d=%0d, write cycles %0d, mem[9]=%0d", wd, wr, mem[9]);
      chk("wr_first_port", 32'(wd), 32'(1));
      chk("wr_cycles", 32'(wr), 32'(2));
      chk("wr_mem9", 32'(mem[9]), 32'(77));
      wait_any(cb, wd, rd, wr);
      if_req = 1'b0;
      $display("instr read adr 4: ack port d=%0d, if_rdata %0d, gap %0d", wd, if_rdata, cb - ca);
      chk("if_second_port", 32'(wd), 32'(0));
      chk("if_rdata_4", 32'(if_rdata), 32'(4));
      chk("if_after_wr_gap", 32'(cb - ca), 32'(AC + 2));
      chk("d_rdata_kept", 32'(d_rdata), 32'(15));

      // Both ports requesting continuously.
      @(posedge clk); #1;
      if_req = 1'b1; if_adr = 8'd4;
      d_req = 1'b1; d_we = 1'b0; d_adr = 8'd5;
      exp_pat = "DDDDIDDDDI";
      prev = 0;
      for (int i = 0; i < 10; i++) begin
         wait_any(ca, wd, rd, wr);
         got[i] = wd ? 8'h44 : 8'h49;
         if (i == 9) begin
            if_req = 1'b0; d_req = 1'b0;
         end
         $display("continuous grant %0d: port %s at cycle %0d", i, wd ? "D" : "I", ca);
         chk("grant_order", 32'(got[i]), 32'(exp_pat[i]));
         if (i > 0) chk("grant_period", 32'(ca - prev), 32'(AC + 2));
         prev = ca;
      end

      // Reset during the second busy cycle of a write.
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b1; d_adr = 8'd9; d_wdata = 16'd33;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk("abort_busy_write", 32'(mem_write), 32'(1));
      @(negedge clk);
      $display("abort: mem_write %0d d_ack %0d mem_adr %0d", mem_write, d_ack, mem_adr);
      chk("abort_ctrl_zero", {mem_read, mem_write, if_ack, d_ack, 28'h0}, 32'h0);
      chk("abort_data_zero", {mem_adr, mem_wdata, 8'h0}, 32'h0);
      chk("abort_rdata_zero", {if_rdata, d_rdata}, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      wr = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (d_ack || if_ack) wr++;
      end
      chk("abort_no_ack", 32'(wr), 32'(0));

      // One-cycle accesses: instruction read then data read.
      @(posedge clk); #1;
      u1_if_req = 1'b1; u1_if_adr = 8'd4;
      ci = -1; cd = -1; u1_rd = 0; u1_wr = 0;
      for (int i = 0; i < 20 && ci < 0; i++) begin
         @(negedge clk);
         if (u1_if_ack) begin
            ci = cyc;
            u1_if_req = 1'b0;
            u1_d_req = 1'b1; u1_d_we = 1'b0; u1_d_adr = 8'd5;
         end
      end
      chk("ac1_if_ack_seen", 32'(ci >= 0), 32'(1));
      chk("ac1_if_rdata", 32'(u1_if_rdata), 32'(4));
      for (int i = 0; i < 20 && cd < 0; i++) begin
         @(negedge clk);
         if (u1_mem_read)  u1_rd++;
         if (u1_mem_write) u1_wr++;
         if (u1_d_ack) begin
            cd = cyc;
            u1_d_req = 1'b0;
         end
      end
      $display("AC=1: if_ack cycle %0d, d_ack cycle %0d, d_rdata %0d, if_rdata %0d",
               ci, cd, u1_d_rdata, u1_if_rdata);
      chk("ac1_d_ack_seen", 32'(cd >= 0), 32'(1));
      chk("ac1_ack_gap", 32'(cd - ci), 32'(3));
      chk("ac1_d_rdata", 32'(u1_d_rdata), 32'(15));
      chk("ac1_if_rdata_held", 32'(u1_if_rdata), 32'(4));
      chk("ac1_read_cycles", 32'(u1_rd), 32'(1));
      chk("ac1_no_write", 32'(u1_wr), 32'(0));

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
